counter_chain_ctrl: RTL

Command-driven sequencer for the chained three-stage counter datapath. It accepts LOAD, COUNT and CLEAR commands through a valid/ready handshake and drives the datapath's shared inc, ld and data_in strobes. LOAD shifts a full multi-digit value through the chain one digit per cycle. The block also watches the datapath's OR-reduced error output and latches a sticky fault.

---
 rtl/counter_chain_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/counter_chain_ctrl.sv
// counter_chain_ctrl: command sequencer for the chained counter datapath.
// Accepts CLEAR / LOAD / COUNT over valid/ready, drives the shared ld/inc/data
// strobes, and latches a sticky fault on datapath error or illegal op.
// Optional: define CTRL_INC_TALLY_EN to add the saturating inc_total counter.
module counter_chain_ctrl #(
    parameter int STAGES = 3,
    parameter int WIDTH  = 3,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [STAGES*WIDTH-1:0]   cmd_arg,
    output logic                      cnt_inc,
    output logic                      cnt_ld,
    output logic [WIDTH-1:0]          cnt_data,
    input  logic                      cnt_error,
    output logic                      busy,
    output logic                      done,
    output logic                      fault,
    output logic [1:0]                fault_code
`ifdef CTRL_INC_TALLY_EN
    ,
    output logic [15:0]               inc_total
`endif
);

    localparam int DW = STAGES * WIDTH;
    localparam int SW = $clog2(STAGES + 1);
    localparam int RW = (CNT_W > SW) ? CNT_W : SW;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_COUNT = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COUNT, S_FAULT} state_t;

    state_t           state, state_n;
    logic [RW-1:0]    rem, rem_n;     // strobes still to issue after the current one
    logic [DW-1:0]    sh, sh_n;       // remaining LOAD digits, most significant at top
    logic             accept;
    logic [CNT_W-1:0] n_arg;

    logic             ld_n, inc_n, busy_n, done_n, fault_n, ready_n;
    logic [WIDTH-1:0] data_n;
    logic [1:0]       code_n;

    assign accept = cmd_valid && cmd_ready;
    assign n_arg  = cmd_arg[CNT_W-1:0];

    // State, sequencing counters and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rem        <= '0;
            sh         <= '0;
            cnt_ld     <= 1'b0;
            cnt_inc    <= 1'b0;
            cnt_data   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
            cmd_ready  <= 1'b1;
        end else begin
            state      <= state_n;
            rem        <= rem_n;
            sh         <= sh_n;
            cnt_ld     <= ld_n;
            cnt_inc    <= inc_n;
            cnt_data   <= data_n;
            busy       <= busy_n;
            done       <= done_n;
            fault      <= fault_n;
            fault_code <= code_n;
            cmd_ready  <= ready_n;
        end
    end

    // Next state; datapath error outranks everything outside FAULT
    always_comb begin
        state_n = state;
        rem_n   = rem;
        sh_n    = sh;
        case (state)
            S_IDLE: begin
                if (cnt_error) begin
                    state_n = S_FAULT;
                end else if (accept) begin
                    case (cmd_op)
                        OP_CLEAR: state_n = S_IDLE;
                        OP_LOAD: begin
                            state_n = S_LOAD;
                            rem_n   = RW'(STAGES - 1);
                            sh_n    = cmd_arg << WIDTH;
                        end
                        OP_COUNT: begin
                            if (n_arg != '0) begin
                                state_n = S_COUNT;
                                rem_n   = RW'(n_arg) - RW'(1);
                            end
                        end
                        default: state_n = S_FAULT;
                    endcase
                end
            end
            S_LOAD: begin
                if (cnt_error)        state_n = S_FAULT;
                else if (rem == '0)   state_n = S_IDLE;
                else begin
                    rem_n = rem - RW'(1);
                    sh_n  = sh << WIDTH;
                end
            end
            S_COUNT: begin
                if (cnt_error)        state_n = S_FAULT;
                else if (rem == '0)   state_n = S_IDLE;
                else                  rem_n = rem - RW'(1);
            end
            default: begin
                if (accept && cmd_op == OP_CLEAR) state_n = S_IDLE;
            end
        endcase
    end

    // Output values for the next cycle, derived from the state being entered
    always_comb begin
        ld_n    = (state_n == S_LOAD);
        inc_n   = (state_n == S_COUNT);
        busy_n  = ld_n || inc_n;
        ready_n = (state_n == S_IDLE) || (state_n == S_FAULT);
        data_n  = '0;
        if (ld_n)
            data_n = (state == S_IDLE) ? cmd_arg[DW-1 -: WIDTH] : sh[DW-1 -: WIDTH];
        // any arrival in IDLE other than an idle cycle is a normal completion
        done_n  = (state_n == S_IDLE) && ((state != S_IDLE) || accept);
        fault_n = (state_n == S_FAULT);
        code_n  = fault_code;
        if (state_n != S_FAULT)
            code_n = 2'b00;
        else if (state != S_FAULT)
            code_n = cnt_error ? 2'b01 : 2'b10;
    end

`ifdef CTRL_INC_TALLY_EN
    // Saturating tally of inc strobes, cleared after any accepted CLEAR
    always_ff @(posedge clk) begin
        if (rst)
            inc_total <= '0;
        else if (accept && cmd_op == OP_CLEAR)
            inc_total <= '0;
        else if (cnt_inc && inc_total != 16'hFFFF)
            inc_total <= inc_total + 16'd1;
    end
`endif

endmodule
